// File: rtl/tag_ram_pkg.sv
// Shared definitions for the N-way tag RAM.
//   state_e : controller state encoding (INIT = 0, IDLE = 1)
package tag_ram_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

endpackage : tag_ram_pkg

// File: rtl/tag_ram_nway_if.sv
// Request/response bundle for tag_ram_nway.
//   master drives : rd_en, addr, we[NWAYS], din, cmp_tag
//   slave drives  : ready, dout[NWAYS*DWIDTH], dout_valid, hit[NWAYS]
interface tag_ram_nway_if #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 9,
  parameter int unsigned NWAYS  = 2
);

  logic                     ready;
  logic                     rd_en;
  logic [AWIDTH-1:0]        addr;
  logic [NWAYS-1:0]         we;
  logic [DWIDTH-1:0]        din;
  logic [DWIDTH-1:0]        cmp_tag;
  logic [NWAYS*DWIDTH-1:0]  dout;
  logic                     dout_valid;
  logic [NWAYS-1:0]         hit;

  modport master (
    output rd_en, addr, we, din, cmp_tag,
    input  ready, dout, dout_valid, hit
  );

  modport slave (
    input  rd_en, addr, we, din, cmp_tag,
    output ready, dout, dout_valid, hit
  );

endinterface : tag_ram_nway_if

// File: rtl/tag_ram_way.sv
// One way of the tag RAM: single-port DEPTH x DWIDTH array with a registered
// write and a write-first registered read.
//   clk, rst_n  : clock, synchronous active-low reset (clears read register)
//   we_i, re_i  : write / read enable for this cycle
//   addr_i      : shared address
//   din_i       : write data
//   rd_word_c   : combinational write-first read word (feeds the tag compare)
//   rdata_o     : registered read data, holds while re_i is low
module tag_ram_way #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] din_i,
  output logic [DWIDTH-1:0] rd_word_c,
  output logic [DWIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  // Storage array; contents only ever set by writes (no reset).
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  // A same-cycle write bypasses the array so the read sees the new data.
  assign rd_word_c = we_i ? din_i : mem_q[addr_i];

  // Read register, cleared by reset and held between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rd_word_c;
    end
  end

  assign rdata_o = rdata_q;

endmodule : tag_ram_way

// File: rtl/tag_ram_nway.sv
// N-way tag RAM with self-initialisation and registered per-way tag compare.
// After reset an internal walker writes INIT_VAL to every address of every
// way (DEPTH cycles); requests are accepted only once ready is high.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : rd_en/addr/we/din/cmp_tag in,
//                    ready/dout/dout_valid/hit out (all registered)
module tag_ram_nway
  import tag_ram_pkg::*;
#(
  parameter int unsigned       AWIDTH   = 3,
  parameter int unsigned       DWIDTH   = 9,
  parameter int unsigned       NWAYS    = 2,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input logic            clock,
  input logic            reset_n,
  tag_ram_nway_if.slave  bus
);

  localparam int unsigned       DEPTH     = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic [NWAYS-1:0]    hit_q, hit_d;

  logic [NWAYS-1:0]    way_we_c;
  logic [AWIDTH-1:0]   way_addr_c;
  logic [DWIDTH-1:0]   way_din_c;
  logic                rd_go_c;
  logic [DWIDTH-1:0]   rd_word [NWAYS];
  logic [DWIDTH-1:0]   rdata   [NWAYS];

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      hit_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      hit_q      <= hit_d;
    end
  end

  // Next state, init mux onto the array ports, and tag compare.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    way_we_c   = '0;
    way_addr_c = bus.addr;
    way_din_c  = bus.din;
    rd_go_c    = 1'b0;

    case (state_q)
      INIT: begin
        // Walk every address once, writing INIT_VAL into all ways.
        way_we_c   = '1;
        way_addr_c = init_cnt_q;
        way_din_c  = INIT_VAL;
        init_cnt_d = init_cnt_q + AWIDTH'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        way_we_c = bus.we;
        rd_go_c  = bus.rd_en;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    ready_d = (state_d == IDLE);
    valid_d = rd_go_c;

    // Compare against the write-first word so hit lines up with dout.
    hit_d = hit_q;
    if (rd_go_c) begin
      for (int unsigned w = 0; w < NWAYS; w++) begin
        hit_d[w] = (rd_word[w] == bus.cmp_tag);
      end
    end
  end

  // One RAM instance per way; dout is the concatation of the read registers.
  for (genvar w = 0; w < NWAYS; w++) begin : g_way
    tag_ram_way #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
    ) u_way (
      .clk       (clock),
      .rst_n     (reset_n),
      .we_i      (way_we_c[w]),
      .re_i      (rd_go_c),
      .addr_i    (way_addr_c),
      .din_i     (way_din_c),
      .rd_word_c (rd_word[w]),
      .rdata_o   (rdata[w])
    );

    assign bus.dout[w*DWIDTH +: DWIDTH] = rdata[w];
  end

  assign bus.ready      = ready_q;
  assign bus.dout_valid = valid_q;
  assign bus.hit        = hit_q;

endmodule : tag_ram_nway

// File: tb/tb_tag_ram_nway.sv
// Bench for tag_ram_nway: two instances (defaults, and 4 ways x 32 entries
// with a non-zero INIT_VAL) driven by common stimulus and checked every cycle
// against a behavioural model, with hand-computed pins for known scenarios.
module tb_tag_ram_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s;
  logic       rd_s;
  logic [4:0] addr_s;
  logic [3:0] we_s;
  logic [8:0] din_s;
  logic [8:0] cmp_s;

  tag_ram_nway_if #(.AWIDTH(3), .DWIDTH(9), .NWAYS(2)) bus_a ();
  tag_ram_nway_if #(.AWIDTH(5), .DWIDTH(9), .NWAYS(4)) bus_b ();

  assign bus_a.rd_en   = rd_s;
  assign bus_a.addr    = addr_s[2:0];
  assign bus_a.we      = we_s[1:0];
  assign bus_a.din     = din_s;
  assign bus_a.cmp_tag = cmp_s;

  assign bus_b.rd_en   = rd_s;
  assign bus_b.addr    = addr_s;
  assign bus_b.we      = we_s;
  assign bus_b.din     = din_s;
  assign bus_b.cmp_tag = cmp_s;

  tag_ram_nway #(.AWIDTH(3), .DWIDTH(9), .NWAYS(2), .INIT_VAL(9'h000)) dut_a (
    .clock   (clk),
    .reset_n (rst_n_s),
    .bus     (bus_a.slave)
  );

  tag_ram_nway #(.AWIDTH(5), .DWIDTH(9), .NWAYS(4), .INIT_VAL(9'h155)) dut_b (
    .clock   (clk),
    .reset_n (rst_n_s),
    .bus     (bus_b.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state, index 0 = dut_a, 1 = dut_b.
  logic [8:0]  m_mem [2][32][4];
  int          m_left  [2];
  bit          m_ready [2];
  bit          m_valid [2];
  logic [35:0] m_dout  [2];
  logic [3:0]  m_hit   [2];

  function automatic int dep_of(input int i);
    return (i == 0) ? 8 : 32;
  endfunction

  function automatic int nw_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic logic [8:0] ival_of(input int i);
    return (i == 0) ? 9'h000 : 9'h155;
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    int         a;
    logic [8:0] d;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n_s) begin
        m_left[i]  = dep_of(i);
        m_ready[i] = 1'b0;
        m_valid[i] = 1'b0;
        m_dout[i]  = '0;
        m_hit[i]   = '0;
      end else if (!m_ready[i]) begin
        m_valid[i] = 1'b0;
        if (m_left[i] > 0) m_left[i]--;
        if (m_left[i] == 0) begin
          for (int x = 0; x < dep_of(i); x++)
            for (int w = 0; w < nw_of(i); w++)
              m_mem[i][x][w] = ival_of(i);
          m_ready[i] = 1'b1;
        end
      end else begin
        a = int'(addr_s) % dep_of(i);
        m_valid[i] = rd_s;
        if (rd_s) begin
          for (int w = 0; w < nw_of(i); w++) begin
            d = we_s[w] ? din_s : m_mem[i][a][w];
            m_dout[i][w*9 +: 9] = d;
            m_hit[i][w] = (d == cmp_s);
          end
        end
        for (int w = 0; w < nw_of(i); w++)
          if (we_s[w]) m_mem[i][a][w] = din_s;
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_all();
    logic [35:0] e;
    logic [3:0]  h;
    check("a_ready", 36'(bus_a.ready), 36'(m_ready[0]));
    check("a_valid", 36'(bus_a.dout_valid), 36'(m_valid[0]));
    e = m_dout[0];
    check("a_dout", 36'(bus_a.dout), 36'(e[17:0]));
    h = m_hit[0];
    check("a_hit", 36'(bus_a.hit), 36'(h[1:0]));
    check("b_ready", 36'(bus_b.ready), 36'(m_ready[1]));
    check("b_valid", 36'(bus_b.dout_valid), 36'(m_valid[1]));
    check("b_dout", 36'(bus_b.dout), m_dout[1]);
    check("b_hit", 36'(bus_b.hit), 36'(m_hit[1]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic r, input logic rd, input logic [4:0] ad,
                       input logic [3:0] w, input logic [8:0] d, input logic [8:0] c);
    rst_n_s = r;
    rd_s    = rd;
    addr_s  = ad;
    we_s    = w;
    din_s   = d;
    cmp_s   = c;
  endtask

  // Release reset and count edges until each instance reports ready.
  task automatic init_len(input bit poke, output int len_a, output int len_b);
    len_a = -1;
    len_b = -1;
    for (int k = 0; k < 100; k++) begin
      if (poke && !bus_a.ready) drive(1'b1, 1'b1, 5'(k), 4'hF, 9'h1FF, 9'h000);
      else                      drive(1'b1, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
      step();
      if (len_a < 0 && bus_a.ready) len_a = k + 1;
      if (len_b < 0 && bus_b.ready) len_b = k + 1;
      if (len_a >= 0 && len_b >= 0) break;
    end
  endtask

  initial begin
    int         la, lb, nvalid, ra;
    logic [8:0] ctag;

    drive(1'b0, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
    @(negedge clk);
    step();
    step();
    check("rst_ready", 36'(bus_a.ready), 36'd0);
    check("rst_valid", 36'(bus_a.dout_valid), 36'd0);
    check("rst_dout", 36'(bus_a.dout), 36'd0);
    check("rst_hit", 36'(bus_a.hit), 36'd0);

    // Requests poked during INIT must be ignored.
    init_len(1'b1, la, lb);
    check("a_init_len", 36'(la), 36'd8);
    check("b_init_len", 36'(lb), 36'd32);

    // Back-to-back reads of every address of dut_a.
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'(i), 4'h0, 9'h000, 9'h000);
      step();
      if (bus_a.dout_valid) nvalid++;
      check("a_init_data", 36'(bus_a.dout), 36'd0);
      check("a_init_hit", 36'(bus_a.hit), 36'h3);
      check("b_init_data", 36'(bus_b.dout), 36'({4{9'h155}}));
    end
    check("a_b2b_pulses", 36'(nvalid), 36'd8);
    drive(1'b1, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
    step();
    check("a_valid_idle", 36'(bus_a.dout_valid), 36'd0);

    // Write way 1 at addr 5, then read it back with a matching tag.
    drive(1'b1, 1'b0, 5'd5, 4'b0010, 9'h1A5, 9'h000);
    step();
    drive(1'b1, 1'b1, 5'd5, 4'b0000, 9'h000, 9'h1A5);
    step();
    check("wr_rd_dout", 36'(bus_a.dout), 36'({9'h1A5, 9'h000}));
    check("wr_rd_hit", 36'(bus_a.hit), 36'h2);
    check("wr_rd_valid", 36'(bus_a.dout_valid), 36'd1);

    // Same-cycle write and read at addr 3 is write-first on way 0 only.
    drive(1'b1, 1'b0, 5'd3, 4'b0010, 9'h03C, 9'h000);
    step();
    drive(1'b1, 1'b1, 5'd3, 4'b0001, 9'h0F0, 9'h0F0);
    step();
    check("wf_dout", 36'(bus_a.dout), 36'({9'h03C, 9'h0F0}));
    check("wf_hit", 36'(bus_a.hit), 36'h1);
    drive(1'b1, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
    step();
    check("hold_dout", 36'(bus_a.dout), 36'({9'h03C, 9'h0F0}));
    check("hold_valid", 36'(bus_a.dout_valid), 36'd0);

    // Reset at INIT cycle 4 restarts a full initialisation.
    drive(1'b0, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
      step();
    end
    drive(1'b0, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
    step();
    check("midinit_ready", 36'(bus_a.ready), 36'd0);
    init_len(1'b0, la, lb);
    check("reinit_len_a", 36'(la), 36'd8);
    check("reinit_len_b", 36'(lb), 36'd32);
    drive(1'b1, 1'b1, 5'd5, 4'h0, 9'h000, 9'h000);
    step();
    check("reinit_data", 36'(bus_a.dout), 36'd0);
    check("reinit_hit", 36'(bus_a.hit), 36'h3);

    // Reset one cycle after a read, and together with a read.
    drive(1'b1, 1'b1, 5'd6, 4'h0, 9'h000, 9'h000);
    step();
    drive(1'b0, 1'b1, 5'd7, 4'h0, 9'h000, 9'h000);
    step();
    check("rdrst_valid", 36'(bus_a.dout_valid), 36'd0);
    check("rdrst_dout", 36'(bus_a.dout), 36'd0);
    check("rdrst_hit", 36'(bus_a.hit), 36'd0);
    init_len(1'b0, la, lb);
    check("rdrst_len_a", 36'(la), 36'd8);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      ra = int'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) ctag = m_mem[0][ra % 8][$urandom_range(0, 1)];
      else                           ctag = 9'($urandom);
      drive(($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 1)),
            5'(ra),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
            9'($urandom),
            ctag);
      step();
    end

    // Sweep all 32 addresses of dut_b back to back once it is ready.
    for (int k = 0; k < 40 && !bus_b.ready; k++) begin
      drive(1'b1, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
      step();
    end
    check("b_ready_sweep", 36'(bus_b.ready), 36'd1);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 5'(i), 4'h0, 9'h000, 9'h155);
      step();
    end
    drive(1'b1, 1'b0, 5'd0, 4'h0, 9'h000, 9'h000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tag_ram_nway
